// File: rtl/fxp_accum_seq.sv
// fxp_accum_seq: sums len fixed-point terms with a dynamic Q format.
// Ports: start/len job, in_valid/in_ready/in_data operand stream,
//   out_valid/out_ready/out_sum/out_qi/out_qf result, busy status.
// Option FXP_ALIGN_SAT_EN: clamp lossy alignment shifts, add sat_flag.
module fxp_accum_seq #(
   parameter int WORD_SIZE = 16,
   parameter int LEN_W     = 8,
   parameter int QI_IN     = 4,
   parameter int QF_IN     = 12
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [LEN_W-1:0]     len,
   input  logic                 in_valid,
   input  logic [WORD_SIZE-1:0] in_data,
   output logic                 in_ready,
   output logic                 busy,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WORD_SIZE-1:0] out_sum,
   output logic [3:0]           out_qi,
   output logic [3:0]           out_qf
`ifdef FXP_ALIGN_SAT_EN
   ,
   output logic                 sat_flag
`endif
);

   localparam int W = WORD_SIZE;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_ALIGN,
      S_ADD,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [W-1:0]     acc_q, acc_d;
   logic [W-1:0]     op_q, op_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [3:0]       qi_q, qi_d;
   logic [3:0]       qf_q, qf_d;
`ifdef FXP_ALIGN_SAT_EN
   logic             sat_q, sat_d;
`endif

   logic [LEN_W-1:0] cnt_inc;
   logic signed [5:0] d;
   logic [4:0]       sh_r;
   logic [4:0]       sh_l;
   logic [W-1:0]     op_r;
   logic [W-1:0]     op_l;
   logic [W-1:0]     op_back;
`ifdef FXP_ALIGN_SAT_EN
   logic             lost;
   logic [W-1:0]     sat_val;
`endif
   logic [W-1:0]     sum_t;
   logic [W-1:0]     acc_h;
   logic [W-1:0]     op_h;
   logic             ovf;

   assign cnt_inc = cnt_q + LEN_W'(1);

   // Alignment distance from operand format to accumulator format.
   assign d    = $signed(6'(QF_IN)) - $signed({2'b00, qf_q});
   assign sh_r = d[4:0];
   assign sh_l = 5'(-d);

   assign op_r    = $signed(op_q) >>> sh_r;
   assign op_l    = op_q << sh_l;
   // Shifting back exposes any significant bits lost off the top.
   assign op_back = $signed(op_l) >>> sh_l;

`ifdef FXP_ALIGN_SAT_EN
   assign lost    = (op_back != op_q);
   assign sat_val = op_q[W-1] ? {1'b1, {(W-1){1'b0}}}
                              : {1'b0, {(W-1){1'b1}}};
`endif

   assign sum_t = acc_q + op_q;
   assign acc_h = $signed(acc_q) >>> 1;
   assign op_h  = $signed(op_q) >>> 1;
   assign ovf   = (acc_q[W-1] == op_q[W-1]) &&
                  (sum_t[W-1] != acc_q[W-1]);

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      op_d    = op_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      qi_d    = qi_q;
      qf_d    = qf_q;
`ifdef FXP_ALIGN_SAT_EN
      sat_d   = sat_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               len_d = len;
               cnt_d = '0;
               acc_d = '0;
               qi_d  = 4'(QI_IN);
               qf_d  = 4'(QF_IN);
`ifdef FXP_ALIGN_SAT_EN
               sat_d = 1'b0;
`endif
               state_d = (len == '0) ? S_DONE : S_WAIT;
            end
         end
         S_WAIT: begin
            if (in_valid) begin
               if (cnt_q == '0) begin
                  acc_d   = in_data;
                  cnt_d   = LEN_W'(1);
                  state_d = (len_q == LEN_W'(1)) ? S_DONE : S_WAIT;
               end else begin
                  op_d    = in_data;
                  state_d = S_ALIGN;
               end
            end
         end
         S_ALIGN: begin
            if (d > 0) begin
               op_d = op_r;
            end else if (d < 0) begin
               op_d = op_l;
`ifdef FXP_ALIGN_SAT_EN
               if (lost) begin
                  op_d  = sat_val;
                  sat_d = 1'b1;
               end
`endif
            end
            state_d = S_ADD;
         end
         S_ADD: begin
            if (ovf) begin
               acc_d = acc_h + op_h;
               qi_d  = qi_q + 4'd1;
               qf_d  = qf_q - 4'd1;
            end else if ((sum_t[W-1] == sum_t[W-2]) &&
                         (qi_q != 4'd1)) begin
               // Redundant sign bit: trade an integer bit for precision.
               acc_d = sum_t << 1;
               qi_d  = qi_q - 4'd1;
               qf_d  = qf_q + 4'd1;
            end else begin
               acc_d = sum_t;
            end
            cnt_d   = cnt_inc;
            state_d = (cnt_inc == len_q) ? S_DONE : S_WAIT;
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         acc_q   <= '0;
         op_q    <= '0;
         cnt_q   <= '0;
         len_q   <= '0;
         qi_q    <= 4'(QI_IN);
         qf_q    <= 4'(QF_IN);
`ifdef FXP_ALIGN_SAT_EN
         sat_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         qi_q    <= qi_d;
         qf_q    <= qf_d;
`ifdef FXP_ALIGN_SAT_EN
         sat_q   <= sat_d;
`endif
      end
   end

   assign in_ready  = (state_q == S_WAIT);
   assign busy      = (state_q != S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign out_sum   = acc_q;
   assign out_qi    = qi_q;
   assign out_qf    = qf_q;
`ifdef FXP_ALIGN_SAT_EN
   assign sat_flag  = sat_q;
`endif

endmodule

// File: tb/tb_fxp_accum_seq.sv
// tb_fxp_accum_seq: directed bench for fxp_accum_seq, W=16 Q4.12.
// Drives and samples on the falling edge.
module tb_fxp_accum_seq;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [7:0]  len;
   logic        in_valid;
   logic [15:0] in_data;
   logic        in_ready;
   logic        busy;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_sum;
   logic [3:0]  out_qi;
   logic [3:0]  out_qf;
`ifdef FXP_ALIGN_SAT_EN
   logic        sat_flag;
`endif

   int n_chk;
   int n_fail;

   fxp_accum_seq #(
      .WORD_SIZE(16),
      .LEN_W(8),
      .QI_IN(4),
      .QF_IN(12)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .len(len),
      .in_valid(in_valid),
      .in_data(in_data),
      .in_ready(in_ready),
      .busy(busy),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_sum(out_sum),
      .out_qi(out_qi),
      .out_qf(out_qf)
`ifdef FXP_ALIGN_SAT_EN
      ,
      .sat_flag(sat_flag)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag,
                           input logic [31:0] obs,
                           input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_start(input logic [7:0] l);
      start = 1'b1;
      len   = l;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send(input string tag, input logic [15:0] v);
      int k;
      in_valid = 1'b1;
      in_data  = v;
      k = 0;
      while (!in_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      if (!in_ready) begin
         check_eq({tag, "_timeout"}, 32'(in_ready), 32'd1);
      end else begin
         @(negedge clk);
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_done(input string tag,
                            input logic [15:0] es,
                            input logic [3:0] eqi,
                            input logic [3:0] eqf);
      int k;
      k = 0;
      while (!out_valid && k < 50) begin
         @(negedge clk);
         k++;
      end
      check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
      check_eq({tag, "_sum"}, 32'(out_sum), 32'(es));
      check_eq({tag, "_qi"}, 32'(out_qi), 32'(eqi));
      check_eq({tag, "_qf"}, 32'(out_qf), 32'(eqf));
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check_eq({tag, "_drop"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      n_chk     = 0;
      n_fail    = 0;
      rst_n     = 1'b0;
      start     = 1'b0;
      len       = '0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);

      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_inrdy", 32'(in_ready), 32'd0);
      check_eq("rst_oval", 32'(out_valid), 32'd0);
      check_eq("rst_sum", 32'(out_sum), 32'd0);
      check_eq("rst_qi", 32'(out_qi), 32'd4);
      check_eq("rst_qf", 32'(out_qf), 32'd12);
      rst_n = 1'b1;
      @(negedge clk);

      // 1.0 + 1.0 + 1.0 with one normalization step
      do_start(8'd3);
      check_eq("t1_busy", 32'(busy), 32'd1);
      check_eq("t1_inrdy", 32'(in_ready), 32'd1);
      send("t1a", 16'h1000);
      check_eq("t1_rdy_first", 32'(in_ready), 32'd1);
      send("t1b", 16'h1000);
      check_eq("t1_align_rdy", 32'(in_ready), 32'd0);
      @(negedge clk);
      check_eq("t1_add_rdy", 32'(in_ready), 32'd0);
      @(negedge clk);
      check_eq("t1_acc", 32'(out_sum), 32'h4000);
      check_eq("t1_qi2", 32'(out_qi), 32'd3);
      check_eq("t1_rdy_back", 32'(in_ready), 32'd1);
      send("t1c", 16'h1000);
      wait_done("t1", 16'h6000, 4'd3, 4'd13);

      // 7.0 + 7.0 overflows and widens
      do_start(8'd2);
      send("t2a", 16'h7000);
      send("t2b", 16'h7000);
      wait_done("t2", 16'h7000, 4'd5, 4'd11);

      // empty job
      do_start(8'd0);
      check_eq("t3_oval", 32'(out_valid), 32'd1);
      check_eq("t3_inrdy", 32'(in_ready), 32'd0);
      wait_done("t3", 16'h0000, 4'd4, 4'd12);

      // single term passes straight through
      do_start(8'd1);
      send("t4a", 16'hF000);
      wait_done("t4", 16'hF000, 4'd4, 4'd12);

      // left alignment that loses the top bit
      do_start(8'd3);
      send("t5a", 16'h1000);
      send("t5b", 16'h1000);
      send("t5c", 16'h7000);
`ifdef FXP_ALIGN_SAT_EN
      wait_done("t5", 16'h5FFF, 4'd4, 4'd12);
      check_eq("t5_sat", 32'(sat_flag), 32'd1);
`else
      wait_done("t5", 16'h4000, 4'd2, 4'd14);
`endif

      // result backpressure; start pulses must be ignored
      do_start(8'd1);
      send("t6a", 16'h1234);
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         start = (i == 2);
         len   = 8'd0;
         @(negedge clk);
         check_eq("t6_hold_v", 32'(out_valid), 32'd1);
         check_eq("t6_hold_s", 32'(out_sum), 32'h1234);
      end
      start = 1'b0;
      wait_done("t6", 16'h1234, 4'd4, 4'd12);
      check_eq("t6_idle", 32'(busy), 32'd0);

      // reset in the middle of ALIGN
      do_start(8'd4);
      send("t7a", 16'h1000);
      send("t7b", 16'h2000);
      rst_n = 1'b0;
      #1;
      check_eq("t7_busy", 32'(busy), 32'd0);
      check_eq("t7_inrdy", 32'(in_ready), 32'd0);
      check_eq("t7_oval", 32'(out_valid), 32'd0);
      check_eq("t7_sum", 32'(out_sum), 32'd0);
      check_eq("t7_qi", 32'(out_qi), 32'd4);
      check_eq("t7_qf", 32'(out_qf), 32'd12);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      do_start(8'd2);
      send("t8a", 16'h1000);
      send("t8b", 16'hF000);
      wait_done("t8", 16'h0000, 4'd3, 4'd13);
`ifdef FXP_ALIGN_SAT_EN
      check_eq("t8_sat", 32'(sat_flag), 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
